// File: rtl/pll_lock_sequencer.sv
// Control sequencer for one PLL_CORE site: timed reset, lock wait with timeout/retry,
// lock filtering, lock-loss recovery, standby handling and a sticky fault.
module pll_lock_sequencer #(
    parameter int unsigned RST_CYCLES   = 16,
    parameter int unsigned LOCK_TIMEOUT = 4096,
    parameter int unsigned LOCK_FILTER  = 64,
    parameter int unsigned MAX_RETRIES  = 3,
    localparam int unsigned RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pll_lock,
    input  logic          stdby_req,
    input  logic          restart,
    output logic          pll_reset,
    output logic          pll_stdby,
    output logic          pll_legacy,
    output logic          pll_ready,
    output logic          lock_lost,
    output logic          fault,
    output logic [RW-1:0] retry_cnt,
    output logic [2:0]    state
);

    localparam int unsigned CW = (RST_CYCLES > 1)   ? $clog2(RST_CYCLES)   : 1;
    localparam int unsigned TW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
    localparam int unsigned FW = (LOCK_FILTER > 1)  ? $clog2(LOCK_FILTER)  : 1;

    typedef enum logic [2:0] {
        ST_RESET  = 3'd0,
        ST_WAIT   = 3'd1,
        ST_FILTER = 3'd2,
        ST_LOCKED = 3'd3,
        ST_STDBY  = 3'd4,
        ST_FAULT  = 3'd5
    } state_t;

    state_t        r_state;
    logic          r_sync1;
    logic          r_lock_s;
    logic [CW-1:0] r_cnt;
    logic [TW-1:0] r_tmo;
    logic [FW-1:0] r_filt;
    logic [RW-1:0] r_retry;
    logic          r_lock_lost;
    logic [3:0]    r_outs;     // {pll_reset, pll_stdby, pll_ready, fault}

    logic w_filt_done;
    logic w_tmo_hit;
    logic w_retry_max;
    logic w_stdby_ok;

    // Output pattern registered together with the state it belongs to
    function automatic logic [3:0] f_outs(input state_t s);
        case (s)
            ST_RESET:  f_outs = 4'b1000;
            ST_LOCKED: f_outs = 4'b0010;
            ST_STDBY:  f_outs = 4'b0100;
            ST_FAULT:  f_outs = 4'b1001;
            default:   f_outs = 4'b0000;
        endcase
    endfunction

    assign w_filt_done = (r_state == ST_FILTER) && r_lock_s && (r_filt == FW'(LOCK_FILTER - 1));
    assign w_tmo_hit   = (r_tmo == TW'(LOCK_TIMEOUT - 1));
    assign w_retry_max = (r_retry == RW'(MAX_RETRIES));
    assign w_stdby_ok  = (r_state == ST_RESET) || (r_state == ST_WAIT) ||
                         (r_state == ST_FILTER) || (r_state == ST_LOCKED);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1     <= 1'b0;
            r_lock_s    <= 1'b0;
            r_state     <= ST_RESET;
            r_cnt       <= '0;
            r_tmo       <= '0;
            r_filt      <= '0;
            r_retry     <= '0;
            r_lock_lost <= 1'b0;
            r_outs      <= 4'b1000;
        end else begin
            r_sync1     <= pll_lock;
            r_lock_s    <= r_sync1;
            r_lock_lost <= 1'b0;
            if (restart) begin
                r_state <= ST_RESET;
                r_outs  <= f_outs(ST_RESET);
                r_cnt   <= '0;
                r_retry <= '0;
            end else if (stdby_req && w_stdby_ok) begin
                r_state <= ST_STDBY;
                r_outs  <= f_outs(ST_STDBY);
            end else begin
                case (r_state)
                    ST_RESET: begin
                        if (r_cnt == CW'(RST_CYCLES - 1)) begin
                            r_state <= ST_WAIT;
                            r_outs  <= f_outs(ST_WAIT);
                            r_tmo   <= '0;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                    ST_WAIT, ST_FILTER: begin
                        r_tmo <= r_tmo + TW'(1);
                        // Filter completion beats a simultaneous timeout
                        if (w_filt_done) begin
                            r_state <= ST_LOCKED;
                            r_outs  <= f_outs(ST_LOCKED);
                            r_retry <= '0;
                        end else if (w_tmo_hit) begin
                            if (w_retry_max) begin
                                r_state <= ST_FAULT;
                                r_outs  <= f_outs(ST_FAULT);
                            end else begin
                                r_state <= ST_RESET;
                                r_outs  <= f_outs(ST_RESET);
                                r_cnt   <= '0;
                                r_retry <= r_retry + RW'(1);
                            end
                        end else if (r_state == ST_WAIT) begin
                            if (r_lock_s) begin
                                r_state <= ST_FILTER;
                                r_outs  <= f_outs(ST_FILTER);
                                r_filt  <= '0;
                            end
                        end else if (r_lock_s) begin
                            r_filt <= r_filt + FW'(1);
                        end else begin
                            r_state <= ST_WAIT;
                            r_outs  <= f_outs(ST_WAIT);
                        end
                    end
                    ST_LOCKED: begin
                        if (!r_lock_s) begin
                            r_state     <= ST_RESET;
                            r_outs      <= f_outs(ST_RESET);
                            r_cnt       <= '0;
                            r_lock_lost <= 1'b1;
                        end
                    end
                    ST_STDBY: begin
                        if (!stdby_req) begin
                            r_state <= ST_RESET;
                            r_outs  <= f_outs(ST_RESET);
                            r_cnt   <= '0;
                        end
                    end
                    default: begin
                        r_state <= ST_FAULT;
                        r_outs  <= f_outs(ST_FAULT);
                    end
                endcase
            end
        end
    end

    assign pll_reset  = r_outs[3];
    assign pll_stdby  = r_outs[2];
    assign pll_ready  = r_outs[1];
    assign fault      = r_outs[0];
    assign pll_legacy = 1'b0;
    assign lock_lost  = r_lock_lost;
    assign retry_cnt  = r_retry;
    assign state      = r_state;

endmodule
